blake2b_nonce_search: RTL and testbench
=======================================

Name: blake2b_nonce_search

Overview:
Iterative, parametrised BLAKE2b nonce-search engine. It is the successor to the fixed single-purpose BLAKE2b hash core in the mining datapath.
- Hashes one single-block message per nonce, with a configurable message length, digest length, nonce width and nonce position.
- Sweeps a nonce range and compares each digest against a difficulty target.
- Reports the first hit, or range exhaustion, through a start/done handshake to the host controller.

Parameters:
MSG_BYTES, 80, message length in bytes (1..128); all hashing is a single compression with the final flag set.
OUT_BYTES, 32, digest length in bytes (1..64).
NONCE_BITS, 32, nonce width (8..64, multiple of 8).
NONCE_OFFSET, 72, byte offset of the little-endian nonce within the message; NONCE_OFFSET+NONCE_BITS/8 <= MSG_BYTES.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  pulse; accepted only while busy=0
header  in  MSG_BYTES*8  message template; byte i at [8i+:8]; sampled on accepted start
nonce_start  in  NONCE_BITS  first nonce; sampled on start
nonce_end  in  NONCE_BITS  last nonce, inclusive; sampled on start
target  in  64  hit when digest word0 (LE bytes 0..7 as integer) <= target; sampled on start
busy  out  1  search in progress
done  out  1  one-cycle pulse at end of search
found  out  1  valid with done, held until next start: 1 = hit
nonce_out  out  NONCE_BITS  hit nonce, or last nonce tried if no hit
hash_out  out  OUT_BYTES*8  digest for nonce_out; byte i at [8i+:8]

Behaviour:
- Interface decision: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values:
  - busy, done and found are 0.
  - nonce_out and hash_out are 0.
  - The FSM is in IDLE.
- FSM sequence: IDLE -> INIT -> ROUND -> FINAL -> CHECK, then either INIT (next nonce) or IDLE.
- IDLE:
  - On start, latch all inputs, set busy=1 and go to INIT.
  - A start asserted while busy=1 is ignored.
- INIT, 1 cycle:
  - Build m = header with the nonce bytes overwritten, zero-padded to 128 bytes.
  - h[0] = IV0 ^ 0x01010000 ^ OUT_BYTES; key length is 0.
  - h[1..7] = IV[1..7].
  - v[0..7] = h, v[8..15] = IV.
  - v12 ^= MSG_BYTES, v13 unchanged, v14 = ~v14.
- ROUND, 24 cycles:
  - Round r = 0..11, half s = 0/1.
  - s=0 runs the four column G; s=1 runs the four diagonal G.
  - Message schedule is SIGMA[r mod 10]; rotations are 32/24/16/63.
  - All arithmetic is mod 2^64.
- FINAL, 1 cycle:
  - h[i] ^= v[i] ^ v[i+8].
  - Register the first OUT_BYTES bytes of h (LE) as a candidate digest.
- CHECK, 1 cycle:
  - If word0 <= target: set found=1, nonce_out=nonce, hash_out=digest, pulse done, clear busy, go to IDLE.
  - Else if nonce == nonce_end: set found=0, nonce_out=nonce, hash_out=digest, pulse done, clear busy, go to IDLE.
  - Else: nonce = nonce+1 and go to INIT.
- Throughput: 27 cycles per nonce.
- Latency: start to done = 27*N + 1 cycles, for N nonces tried.
- nonce_start > nonce_end: the nonce wraps modulo 2^NONCE_BITS until it equals nonce_end. The full range is allowed.
- nonce_start == nonce_end: exactly one hash.
- Truncated digests (OUT_BYTES < 8): word0 is zero-extended from the available bytes before the compare.
- Reset asserted mid-search: abort immediately, return all outputs to reset values, no done pulse.
- nonce_out and hash_out update only in CHECK on termination. They are stable otherwise.

Optional Feature:
BLAKE2B_ABORT_EN
- When defined, adds an input port abort (1 bit).
- abort=1 while busy:
  - The FSM goes to IDLE at the next edge.
  - done pulses with found=0.
  - nonce_out = the nonce currently in flight; hash_out is unchanged.
- abort=1 while idle has no effect.
- abort together with the hit in CHECK in the same cycle: the hit wins.
- When undefined, the port does not exist and a search runs to hit or exhaustion.

Decomposition:
- Package blake2b_pkg:
  - IV[0..7] 64-bit constants.
  - SIGMA[10][16] 4-bit permutation table.
  - Rotation constants.
  - FSM state enum.
  - Function computing the parameter-block word.
- Sub-module blake2b_g:
  - Purely combinational G(a,b,c,d,x,y).
  - Instantiated 4x in the top; the top muxes column vs diagonal operand selection.

Test Plan:
1. Known-answer "abc":
   - Stimulus: MSG_BYTES=3, OUT_BYTES=64, NONCE_BITS=8, NONCE_OFFSET=2; header bytes 'a','b'; nonce_start=nonce_end=0x63; target=all-ones.
   - Required: done after 28 cycles, found=1, nonce_out=0x63.
   - Required: hash_out = ba80a53f981c4d0d6a2797b69f12f6e94c212f14685ac4b74b12bb6fdbffa2d17d87c5392aab792dc252d5de4533cc9518d38aa8dbf1925ab92386edd4009923.
2. Miss:
   - Stimulus: same as 1 but target=0x0d4d1c983fa580b9, i.e. word0-1.
   - Required: found=0, nonce_out=0x63, same digest.
3. Sweep with hit at nonce 0x63:
   - Stimulus: same as 1 but nonce_start=0x60, nonce_end=0x70, target=0x0d4d1c983fa580ba.
   - Required: either done at cycle 4*27+1 with nonce_out=0x63, or an earlier reported hit whose recomputed reference digest satisfies word0 <= target. The bench checks each nonce against a C/Python reference model.
4. Wrap range:
   - Stimulus: NONCE_BITS=8, nonce_start=0xFE, nonce_end=0x01, target=0.
   - Required: exactly 4 hashes (0xFE, 0xFF, 0x00, 0x01), found=0, nonce_out=0x01, done at cycle 109.
5. Reset and ignored start:
   - Stimulus: assert rst at cycle 40 of a search.
   - Required: busy, done and found drop to 0 asynchronously; a following start runs normally.
   - Stimulus: start pulsed while busy.
   - Required: no effect on the running search.
6. Abort (BLAKE2B_ABORT_EN defined):
   - Stimulus: abort at cycle 30 of a 10-nonce search.
   - Required: done at cycle 31, found=0, nonce_out=nonce_start+1.

Source files
------------

// File: rtl/blake2b_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : blake2b_pkg
//  Description : Shared constants and types for the BLAKE2b nonce-search
//                engine: initialisation vector, message schedule (SIGMA),
//                G-function rotation amounts, FSM state encoding and the
//                parameter-block word helper.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package blake2b_pkg;

    // BLAKE2b initialisation vector (same as SHA-512 IV)
    localparam logic [63:0] c_iv [8] = '{
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b,
        64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
        64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
    };

    // Message word permutation, one row per round (rounds 10/11 reuse rows 0/1)
    localparam logic [3:0] c_sigma [10][16] = '{
        '{4'd0,  4'd1,  4'd2,  4'd3,  4'd4,  4'd5,  4'd6,  4'd7,  4'd8,  4'd9,  4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15},
        '{4'd14, 4'd10, 4'd4,  4'd8,  4'd9,  4'd15, 4'd13, 4'd6,  4'd1,  4'd12, 4'd0,  4'd2,  4'd11, 4'd7,  4'd5,  4'd3},
        '{4'd11, 4'd8,  4'd12, 4'd0,  4'd5,  4'd2,  4'd15, 4'd13, 4'd10, 4'd14, 4'd3,  4'd6,  4'd7,  4'd1,  4'd9,  4'd4},
        '{4'd7,  4'd9,  4'd3,  4'd1,  4'd13, 4'd12, 4'd11, 4'd14, 4'd2,  4'd6,  4'd5,  4'd10, 4'd4,  4'd0,  4'd15, 4'd8},
        '{4'd9,  4'd0,  4'd5,  4'd7,  4'd2,  4'd4,  4'd10, 4'd15, 4'd14, 4'd1,  4'd11, 4'd12, 4'd6,  4'd8,  4'd3,  4'd13},
        '{4'd2,  4'd12, 4'd6,  4'd10, 4'd0,  4'd11, 4'd8,  4'd3,  4'd4,  4'd13, 4'd7,  4'd5,  4'd15, 4'd14, 4'd1,  4'd9},
        '{4'd12, 4'd5,  4'd1,  4'd15, 4'd14, 4'd13, 4'd4,  4'd10, 4'd0,  4'd7,  4'd6,  4'd3,  4'd9,  4'd2,  4'd8,  4'd11},
        '{4'd13, 4'd11, 4'd7,  4'd14, 4'd12, 4'd1,  4'd3,  4'd9,  4'd5,  4'd0,  4'd15, 4'd4,  4'd8,  4'd6,  4'd2,  4'd10},
        '{4'd6,  4'd15, 4'd14, 4'd9,  4'd11, 4'd3,  4'd0,  4'd8,  4'd12, 4'd2,  4'd13, 4'd7,  4'd1,  4'd4,  4'd10, 4'd5},
        '{4'd10, 4'd2,  4'd8,  4'd4,  4'd7,  4'd6,  4'd1,  4'd5,  4'd15, 4'd11, 4'd9,  4'd14, 4'd3,  4'd12, 4'd13, 4'd0}
    };

    // G-function right-rotation amounts
    localparam int c_rot_0 = 32;
    localparam int c_rot_1 = 24;
    localparam int c_rot_2 = 16;
    localparam int c_rot_3 = 63;

    // 12 rounds x 2 half-rounds (column / diagonal); step counter ends at 23
    localparam logic [4:0] c_last_step = 5'd23;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_ROUND = 3'd2,
        ST_FINAL = 3'd3,
        ST_CHECK = 3'd4
    } state_t;

    // Parameter block word 0: digest length, no key, fanout 1, depth 1
    function automatic logic [63:0] param_word(input int out_bytes);
        return 64'h0000_0000_0101_0000 ^ 64'(out_bytes);
    endfunction

    function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

endpackage
`default_nettype wire

// File: rtl/blake2b_g.sv
`default_nettype none
// ============================================================================
//  Module      : blake2b_g
//  Description : Purely combinational BLAKE2b mixing function G(a,b,c,d,x,y).
//  Ports       : a, b, c, d    - working-vector words in
//                x, y          - message words selected by the schedule
//                a_next..d_next- mixed working-vector words
//  Revision    : 1.0 - initial release
// ============================================================================
module blake2b_g
    import blake2b_pkg::*;
(
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic [63:0] c,
    input  logic [63:0] d,
    input  logic [63:0] x,
    input  logic [63:0] y,
    output logic [63:0] a_next,
    output logic [63:0] b_next,
    output logic [63:0] c_next,
    output logic [63:0] d_next
);

    logic [63:0] w_a1, w_b1, w_c1, w_d1;
    logic [63:0] w_a2, w_b2, w_c2, w_d2;

    always_comb begin
        w_a1 = a + b + x;
        w_d1 = rotr64(d ^ w_a1, c_rot_0);
        w_c1 = c + w_d1;
        w_b1 = rotr64(b ^ w_c1, c_rot_1);
        w_a2 = w_a1 + w_b1 + y;
        w_d2 = rotr64(w_d1 ^ w_a2, c_rot_2);
        w_c2 = w_c1 + w_d2;
        w_b2 = rotr64(w_b1 ^ w_c2, c_rot_3);
    end

    assign a_next = w_a2;
    assign b_next = w_b2;
    assign c_next = w_c2;
    assign d_next = w_d2;

endmodule
`default_nettype wire

// File: rtl/blake2b_nonce_search.sv
`default_nettype none
// ============================================================================
//  Module      : blake2b_nonce_search
//  Description : Iterative BLAKE2b nonce-search engine. For every nonce in
//                [nonce_start .. nonce_end] (wrapping) it hashes one
//                single-block message (final block) in 27 cycles and stops
//                at the first digest whose word0 <= target, or when the
//                range is exhausted.
//  Ports       : clk, rst        - clock, asynchronous active-high reset
//                start           - begin a search (ignored while busy)
//                header          - message template, byte i at [8i+:8]
//                nonce_start/end - inclusive nonce range
//                target          - difficulty target for digest word0
//                abort           - cancel search (BLAKE2B_ABORT_EN only)
//                busy            - search in progress
//                done            - one-cycle end-of-search pulse
//                found           - 1 = hit (valid with done, held)
//                nonce_out       - hit nonce / last nonce tried
//                hash_out        - digest of nonce_out, byte i at [8i+:8]
//  Options     : `define BLAKE2B_ABORT_EN adds the abort input.
//  Revision    : 1.0 - initial release
// ============================================================================
module blake2b_nonce_search
    import blake2b_pkg::*;
#(
    parameter int MSG_BYTES    = 80,
    parameter int OUT_BYTES    = 32,
    parameter int NONCE_BITS   = 32,
    parameter int NONCE_OFFSET = 72
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [MSG_BYTES*8-1:0]  header,
    input  logic [NONCE_BITS-1:0]   nonce_start,
    input  logic [NONCE_BITS-1:0]   nonce_end,
    input  logic [63:0]             target,
`ifdef BLAKE2B_ABORT_EN
    input  logic                    abort,
`endif
    output logic                    busy,
    output logic                    done,
    output logic                    found,
    output logic [NONCE_BITS-1:0]   nonce_out,
    output logic [OUT_BYTES*8-1:0]  hash_out
);

    localparam int NONCE_BYTES = NONCE_BITS / 8;
    localparam int OUT_WORDS   = (OUT_BYTES + 7) / 8;
    localparam int W0_BITS     = ((OUT_BYTES < 8) ? OUT_BYTES : 8) * 8;

    // Chaining value before compression (parameter block folded into word 0)
    function automatic logic [63:0] f_h_init(input int i);
        return (i == 0) ? (c_iv[0] ^ param_word(OUT_BYTES)) : c_iv[i];
    endfunction

    state_t                  r_state, w_state_next;

    logic [MSG_BYTES*8-1:0]  r_header;
    logic [NONCE_BITS-1:0]   r_nonce;
    logic [NONCE_BITS-1:0]   r_nonce_end;
    logic [63:0]             r_target;
    logic [63:0]             r_v [16];
    logic [4:0]              r_step;
    logic [OUT_BYTES*8-1:0]  r_digest;
    logic [63:0]             r_word0;

    logic                    w_accept, w_load_v, w_do_round, w_do_final;
    logic                    w_term_hit, w_term_miss, w_advance, w_abort_term;
    logic                    w_hit, w_last;

    logic [1023:0]           w_msg;
    logic [63:0]             w_m [16];
    logic [63:0]             w_v_init [16];
    logic [63:0]             w_v_round [16];
    logic [63:0]             w_h_word [OUT_WORDS];
    logic [OUT_BYTES*8-1:0]  w_digest;
    logic [63:0]             w_word0;

    logic [3:0]              w_round_idx;
    logic [3:0]              w_sig_row;
    logic                    w_half;

    logic [63:0]             w_ga [4], w_gb [4], w_gc [4], w_gd [4];
    logic [63:0]             w_gx [4], w_gy [4];
    logic [63:0]             w_ga_n [4], w_gb_n [4], w_gc_n [4], w_gd_n [4];

    // ------------------------------------------------------------------
    // Message block: header template with the LE nonce spliced in, padded
    // with zeros to 128 bytes. The nonce only changes in CHECK, so this
    // stays stable for the whole compression and needs no register.
    // ------------------------------------------------------------------
    always_comb begin
        w_msg = '0;
        w_msg[MSG_BYTES*8-1:0] = r_header;
        for (int k = 0; k < NONCE_BYTES; k++) begin
            w_msg[(NONCE_OFFSET+k)*8 +: 8] = r_nonce[k*8 +: 8];
        end
        for (int j = 0; j < 16; j++) begin
            w_m[j] = w_msg[64*j +: 64];
        end
    end

    // Working vector at the start of compression: t0 = MSG_BYTES, final flag
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_v_init[i]     = f_h_init(i);
            w_v_init[i + 8] = c_iv[i];
        end
        w_v_init[12] = c_iv[4] ^ 64'(MSG_BYTES);
        w_v_init[14] = ~c_iv[6];
    end

    // ------------------------------------------------------------------
    // Half-round datapath: step[4:1] is the round, step[0] selects
    // column (0) or diagonal (1) operand routing.
    // ------------------------------------------------------------------
    assign w_round_idx = r_step[4:1];
    assign w_half      = r_step[0];
    assign w_sig_row   = (w_round_idx >= 4'd10) ? (w_round_idx - 4'd10) : w_round_idx;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam int         IB_COL = 4 + gi;
        localparam int         IC_COL = 8 + gi;
        localparam int         ID_COL = 12 + gi;
        localparam int         IB_DIA = 4 + ((gi + 1) % 4);
        localparam int         IC_DIA = 8 + ((gi + 2) % 4);
        localparam int         ID_DIA = 12 + ((gi + 3) % 4);
        localparam logic [1:0] LANE   = 2'(gi);

        assign w_ga[gi] = r_v[gi];
        assign w_gb[gi] = w_half ? r_v[IB_DIA] : r_v[IB_COL];
        assign w_gc[gi] = w_half ? r_v[IC_DIA] : r_v[IC_COL];
        assign w_gd[gi] = w_half ? r_v[ID_DIA] : r_v[ID_COL];
        // Schedule slot = 8*half + 2*lane (+1 for y)
        assign w_gx[gi] = w_m[c_sigma[w_sig_row][{w_half, LANE, 1'b0}]];
        assign w_gy[gi] = w_m[c_sigma[w_sig_row][{w_half, LANE, 1'b1}]];

        blake2b_g u_g (
            .a      (w_ga[gi]),
            .b      (w_gb[gi]),
            .c      (w_gc[gi]),
            .d      (w_gd[gi]),
            .x      (w_gx[gi]),
            .y      (w_gy[gi]),
            .a_next (w_ga_n[gi]),
            .b_next (w_gb_n[gi]),
            .c_next (w_gc_n[gi]),
            .d_next (w_gd_n[gi])
        );
    end

    // Route the G results back to the same slots they were taken from
    always_comb begin
        w_v_round = r_v;
        for (int i = 0; i < 4; i++) begin
            w_v_round[i] = w_ga_n[i];
            if (!w_half) begin
                w_v_round[4 + i]  = w_gb_n[i];
                w_v_round[8 + i]  = w_gc_n[i];
                w_v_round[12 + i] = w_gd_n[i];
            end else begin
                w_v_round[4 + ((i + 1) % 4)]  = w_gb_n[i];
                w_v_round[8 + ((i + 2) % 4)]  = w_gc_n[i];
                w_v_round[12 + ((i + 3) % 4)] = w_gd_n[i];
            end
        end
    end

    // Finalisation: only the words that feed the digest are produced
    always_comb begin
        for (int i = 0; i < OUT_WORDS; i++) begin
            w_h_word[i] = f_h_init(i) ^ r_v[i] ^ r_v[i + 8];
        end
        for (int b = 0; b < OUT_BYTES; b++) begin
            w_digest[8*b +: 8] = w_h_word[b / 8][8*(b % 8) +: 8];
        end
        // Short digests compare as a zero-extended word0
        w_word0 = '0;
        w_word0[W0_BITS-1:0] = w_digest[W0_BITS-1:0];
    end

    assign w_hit  = (r_word0 <= r_target);
    assign w_last = (r_nonce == r_nonce_end);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_load_v     = 1'b0;
        w_do_round   = 1'b0;
        w_do_final   = 1'b0;
        w_term_hit   = 1'b0;
        w_term_miss  = 1'b0;
        w_advance    = 1'b0;
        w_abort_term = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_INIT;
                end
            end
            ST_INIT: begin
                w_load_v     = 1'b1;
                w_state_next = ST_ROUND;
            end
            ST_ROUND: begin
                w_do_round = 1'b1;
                if (r_step == c_last_step) begin
                    w_state_next = ST_FINAL;
                end
            end
            ST_FINAL: begin
                w_do_final   = 1'b1;
                w_state_next = ST_CHECK;
            end
            ST_CHECK: begin
                if (w_hit) begin
                    w_term_hit   = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (w_last) begin
                    w_term_miss  = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_advance    = 1'b1;
                    w_state_next = ST_INIT;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

`ifdef BLAKE2B_ABORT_EN
        // A search that terminates on its own in CHECK (hit or exhaustion)
        // takes precedence over a concurrent abort.
        if (abort && (r_state != ST_IDLE) && !w_term_hit && !w_term_miss) begin
            w_abort_term = 1'b1;
            w_load_v     = 1'b0;
            w_do_round   = 1'b0;
            w_do_final   = 1'b0;
            w_advance    = 1'b0;
            w_state_next = ST_IDLE;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_header    <= '0;
            r_nonce     <= '0;
            r_nonce_end <= '0;
            r_target    <= '0;
            r_v         <= '{default: '0};
            r_step      <= '0;
            r_digest    <= '0;
            r_word0     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            found       <= 1'b0;
            nonce_out   <= '0;
            hash_out    <= '0;
        end else begin
            done <= 1'b0;

            if (w_accept) begin
                r_header    <= header;
                r_nonce     <= nonce_start;
                r_nonce_end <= nonce_end;
                r_target    <= target;
                busy        <= 1'b1;
                found       <= 1'b0;
            end

            if (w_load_v) begin
                r_v    <= w_v_init;
                r_step <= '0;
            end

            if (w_do_round) begin
                r_v    <= w_v_round;
                r_step <= r_step + 5'd1;
            end

            if (w_do_final) begin
                r_digest <= w_digest;
                r_word0  <= w_word0;
            end

            if (w_term_hit || w_term_miss) begin
                found     <= w_term_hit;
                nonce_out <= r_nonce;
                hash_out  <= r_digest;
                done      <= 1'b1;
                busy      <= 1'b0;
            end

            if (w_advance) begin
                r_nonce <= r_nonce + {{(NONCE_BITS-1){1'b0}}, 1'b1};
            end

            if (w_abort_term) begin
                found     <= 1'b0;
                nonce_out <= r_nonce;
                done      <= 1'b1;
                busy      <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_blake2b_nonce_search.sv
`default_nettype none
// ============================================================================
//  Module      : tb_blake2b_nonce_search
//  Description : Directed self-checking bench for blake2b_nonce_search,
//                configured for a 3-byte message ("ab" + 1-byte nonce) with a
//                64-byte digest. Expected digests come from the "abc"
//                known-answer vector and an independent BLAKE2b function.
//                Define BLAKE2B_ABORT_EN to include the abort scenario.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_blake2b_nonce_search;

    localparam int MSG_BYTES    = 3;
    localparam int OUT_BYTES    = 64;
    localparam int NONCE_BITS   = 8;
    localparam int NONCE_OFFSET = 2;
    localparam int MAX_CYC      = 400;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [23:0]  header;
    logic [7:0]   nonce_start;
    logic [7:0]   nonce_end;
    logic [63:0]  target;
`ifdef BLAKE2B_ABORT_EN
    logic         abort;
`endif
    logic         busy;
    logic         done;
    logic         found;
    logic [7:0]   nonce_out;
    logic [511:0] hash_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    blake2b_nonce_search #(
        .MSG_BYTES    (MSG_BYTES),
        .OUT_BYTES    (OUT_BYTES),
        .NONCE_BITS   (NONCE_BITS),
        .NONCE_OFFSET (NONCE_OFFSET)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .header      (header),
        .nonce_start (nonce_start),
        .nonce_end   (nonce_end),
        .target      (target),
`ifdef BLAKE2B_ABORT_EN
        .abort       (abort),
`endif
        .busy        (busy),
        .done        (done),
        .found       (found),
        .nonce_out   (nonce_out),
        .hash_out    (hash_out)
    );

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Independent BLAKE2b reference for the bench configuration
    // ------------------------------------------------------------------
    localparam logic [63:0] RIV [8] = '{
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
    };
    localparam int RSIG [10][16] = '{
        '{ 0, 1, 2, 3, 4, 5, 6, 7, 8, 9,10,11,12,13,14,15},
        '{14,10, 4, 8, 9,15,13, 6, 1,12, 0, 2,11, 7, 5, 3},
        '{11, 8,12, 0, 5, 2,15,13,10,14, 3, 6, 7, 1, 9, 4},
        '{ 7, 9, 3, 1,13,12,11,14, 2, 6, 5,10, 4, 0,15, 8},
        '{ 9, 0, 5, 7, 2, 4,10,15,14, 1,11,12, 6, 8, 3,13},
        '{ 2,12, 6,10, 0,11, 8, 3, 4,13, 7, 5,15,14, 1, 9},
        '{12, 5, 1,15,14,13, 4,10, 0, 7, 6, 3, 9, 2, 8,11},
        '{13,11, 7,14,12, 1, 3, 9, 5, 0,15, 4, 8, 6, 2,10},
        '{ 6,15,14, 9,11, 3, 0, 8,12, 2,13, 7, 1, 4,10, 5},
        '{10, 2, 8, 4, 7, 6, 1, 5,15,11, 9,14, 3,12,13, 0}
    };
    localparam int GIDX [8][4] = '{
        '{0, 4,  8, 12}, '{1, 5,  9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
        '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7,  8, 13}, '{3, 4,  9, 14}
    };

    function automatic logic [511:0] ref_hash(input logic [7:0] n);
        logic [63:0] m [16];
        logic [63:0] v [16];
        logic [63:0] h [8];
        logic [63:0] a, b, c, d;
        logic [511:0] res;
        for (int i = 0; i < 16; i++) m[i] = '0;
        m[0] = {40'd0, n, 8'h62, 8'h61};
        for (int i = 0; i < 8; i++) h[i] = RIV[i];
        h[0] = h[0] ^ 64'h0000_0000_0101_0040;
        for (int i = 0; i < 8; i++) begin
            v[i]     = h[i];
            v[i + 8] = RIV[i];
        end
        v[12] = v[12] ^ 64'd3;
        v[14] = ~v[14];
        for (int r = 0; r < 12; r++) begin
            for (int g = 0; g < 8; g++) begin
                a = v[GIDX[g][0]]; b = v[GIDX[g][1]];
                c = v[GIDX[g][2]]; d = v[GIDX[g][3]];
                a = a + b + m[RSIG[r % 10][2*g]];
                d = d ^ a; d = {d[31:0], d[63:32]};
                c = c + d;
                b = b ^ c; b = {b[23:0], b[63:24]};
                a = a + b + m[RSIG[r % 10][2*g + 1]];
                d = d ^ a; d = {d[15:0], d[63:16]};
                c = c + d;
                b = b ^ c; b = {b[62:0], b[63]};
                v[GIDX[g][0]] = a; v[GIDX[g][1]] = b;
                v[GIDX[g][2]] = c; v[GIDX[g][3]] = d;
            end
        end
        for (int i = 0; i < 8; i++) begin
            h[i] = h[i] ^ v[i] ^ v[i + 8];
            res[64*i +: 64] = h[i];
        end
        return res;
    endfunction

    // Start a search and wait (bounded) for done; optionally pulse a second
    // start, with different operands, once the cycle counter hits inject_at.
    task automatic run_search(input logic [7:0] ns, input logic [7:0] ne, input logic [63:0] tgt,
                              input int inject_at, output int cyc, output bit got);
        cyc = 0;
        got = 1'b0;
        @(negedge clk);
        nonce_start = ns;
        nonce_end   = ne;
        target      = tgt;
        start       = 1'b1;
        while (!got && cyc < MAX_CYC) begin
            @(posedge clk);
            #1;
            cyc++;
            start = 1'b0;
            if (done) begin
                got = 1'b1;
            end else if (cyc == inject_at) begin
                start       = 1'b1;
                nonce_start = 8'h63;
                nonce_end   = 8'h63;
                target      = '1;
            end
        end
    endtask

`ifdef BLAKE2B_ABORT_EN
    task automatic run_abort(input logic [7:0] ns, input logic [7:0] ne, input logic [63:0] tgt,
                             input int abort_at, output int cyc, output bit got);
        cyc = 0;
        got = 1'b0;
        @(negedge clk);
        nonce_start = ns;
        nonce_end   = ne;
        target      = tgt;
        start       = 1'b1;
        while (!got && cyc < MAX_CYC) begin
            @(posedge clk);
            #1;
            cyc++;
            start = 1'b0;
            abort = 1'b0;
            if (done) got = 1'b1;
            else if (cyc == abort_at) abort = 1'b1;
        end
    endtask
`endif

    logic [511:0] kat_be;
    logic [511:0] kat;
    logic [63:0]  word0;
    logic [7:0]   first_hit;
    logic [7:0]   n;
    int           cyc;
    bit           got;
    bit           saw_done;

    initial begin
        kat_be = 512'hba80a53f981c4d0d6a2797b69f12f6e94c212f14685ac4b74b12bb6fdbffa2d17d87c5392aab792dc252d5de4533cc9518d38aa8dbf1925ab92386edd4009923;
        for (int i = 0; i < 64; i++) kat[8*i +: 8] = kat_be[8*(63-i) +: 8];

        rst         = 1'b0;
        start       = 1'b0;
        header      = 24'h00_62_61;
        nonce_start = '0;
        nonce_end   = '0;
        target      = '0;
`ifdef BLAKE2B_ABORT_EN
        abort       = 1'b0;
`endif

        // Reset state
        #2 rst = 1'b1;
        #1;
        check("rst_busy",      busy,      0);
        check("rst_done",      done,      0);
        check("rst_found",     found,     0);
        check("rst_nonce_out", nonce_out, 0);
        check("rst_hash_out",  hash_out,  0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // 1: known answer "abc"
        run_search(8'h63, 8'h63, 64'hffff_ffff_ffff_ffff, 0, cyc, got);
        check("t1_done_seen", got,       1);
        check("t1_cycles",    cyc,       28);
        check("t1_found",     found,     1);
        check("t1_busy",      busy,      0);
        check("t1_nonce",     nonce_out, 8'h63);
        check("t1_hash",      hash_out,  kat);
        @(posedge clk); #1;
        check("t1_done_pulse", done,  0);
        check("t1_found_held", found, 1);

        // 2: miss by one
        run_search(8'h63, 8'h63, 64'h0d4d1c983fa580b9, 0, cyc, got);
        check("t2_done_seen", got,       1);
        check("t2_cycles",    cyc,       28);
        check("t2_found",     found,     0);
        check("t2_nonce",     nonce_out, 8'h63);
        check("t2_hash",      hash_out,  kat);

        // 3: sweep, first hit at or before 0x63
        first_hit = 8'h63;
        for (int k = 8'h60; k <= 8'h63; k++) begin
            n = 8'(k);
            word0 = ref_hash(n)[63:0];
            if (word0 <= 64'h0d4d1c983fa580ba && n < first_hit) first_hit = n;
        end
        run_search(8'h60, 8'h70, 64'h0d4d1c983fa580ba, 0, cyc, got);
        check("t3_done_seen", got,       1);
        check("t3_found",     found,     1);
        check("t3_nonce",     nonce_out, first_hit);
        check("t3_cycles",    cyc,       27 * (int'(first_hit) - 8'h60 + 1) + 1);
        check("t3_hash",      hash_out,  ref_hash(first_hit));

        // 5a: reset in the middle of a search
        @(negedge clk);
        nonce_start = 8'h00;
        nonce_end   = 8'h05;
        target      = '0;
        start       = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1 start = 1'b0;
        end
        check("t5_busy_mid", busy, 1);
        #3 rst = 1'b1;
        #1;
        check("t5_rst_busy",  busy,      0);
        check("t5_rst_done",  done,      0);
        check("t5_rst_found", found,     0);
        check("t5_rst_nonce", nonce_out, 0);
        check("t5_rst_hash",  hash_out,  0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1 if (done) saw_done = 1'b1;
        end
        check("t5_no_done", saw_done, 0);
        check("t5_idle",    busy,     0);
        run_search(8'h63, 8'h63, 64'hffff_ffff_ffff_ffff, 0, cyc, got);
        check("t5_after_cycles", cyc,       28);
        check("t5_after_found",  found,     1);
        check("t5_after_hash",   hash_out,  kat);

        // 4 + 5b: wrapping range, with a start pulse mid-search
        run_search(8'hfe, 8'h01, 64'h0, 50, cyc, got);
        check("t4_done_seen", got,       1);
        check("t4_cycles",    cyc,       109);
        check("t4_found",     found,     0);
        check("t4_nonce",     nonce_out, 8'h01);
        check("t4_hash",      hash_out,  ref_hash(8'h01));

`ifdef BLAKE2B_ABORT_EN
        // 6: abort during the second nonce of a 10-nonce search
        run_abort(8'h10, 8'h19, 64'h0, 30, cyc, got);
        check("t6_done_seen", got,       1);
        check("t6_cycles",    cyc,       31);
        check("t6_found",     found,     0);
        check("t6_nonce",     nonce_out, 8'h11);
        check("t6_hash_kept", hash_out,  ref_hash(8'h01));
        @(posedge clk); #1;
        check("t6_idle", busy, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
